// File: rtl/xbar_slave_port.sv
// Small synchronous FIFO used for the outer request channels.
// Latency: one cycle from push to head visibility; head is read combinationally.
// Backpressure: full blocks pushes and empty blocks pops, even if the opposite side is active in the same cycle.
module xbar_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full
);
    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    localparam int PW = $clog2(DEPTH) + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr[PW-2:0]];

    // Advance the pointers; reset discards all stored entries.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Write the storage array; contents are meaningless until pointed at.
    always_ff @(posedge ACLK) begin
        if (do_push) mem[wr_ptr[PW-2:0]] <= push_dat;
    end
endmodule

// Crossbar slave port: queues outer AR/AW/W requests and returns R/B from downstream slaves.
// Latency: requests visible at FIFO head one cycle after handshake; returns add one arbitration cycle per burst/response.
// Backpressure: READY drops when a FIFO is full; R/B hold grant and payload until RREADY/BREADY.
module xbar_slave_port #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int SIZE_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4,
    parameter int DEPTH      = 4,
    parameter int SLAVES     = 2,
    localparam int SB        = $clog2(SLAVES)
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    // outer AR
    input  logic [ID_WIDTH-1:0]               ARID,
    input  logic [ADDR_WIDTH-1:0]             ARADDR,
    input  logic [LEN_WIDTH-1:0]              ARLEN,
    input  logic [SIZE_WIDTH-1:0]             ARSIZE,
    input  logic [1:0]                        ARBURST,
    input  logic                              ARVALID,
    output logic                              ARREADY,
    // outer AW
    input  logic [ID_WIDTH-1:0]               AWID,
    input  logic [ADDR_WIDTH-1:0]             AWADDR,
    input  logic [LEN_WIDTH-1:0]              AWLEN,
    input  logic [SIZE_WIDTH-1:0]             AWSIZE,
    input  logic [1:0]                        AWBURST,
    input  logic                              AWVALID,
    output logic                              AWREADY,
    // outer W
    input  logic [DATA_WIDTH-1:0]             WDATA,
    input  logic [STRB_WIDTH-1:0]             WSTRB,
    input  logic                              WLAST,
    input  logic                              WVALID,
    output logic                              WREADY,
    // outer R
    output logic [ID_WIDTH-1:0]               RID,
    output logic [DATA_WIDTH-1:0]             RDATA,
    output logic [1:0]                        RRESP,
    output logic                              RLAST,
    output logic                              RVALID,
    input  logic                              RREADY,
    // outer B
    output logic [ID_WIDTH-1:0]               BID,
    output logic [1:0]                        BRESP,
    output logic                              BVALID,
    input  logic                              BREADY,
    // AR FIFO head toward crossbar
    output logic                              ar_empty,
    output logic [SB-1:0]                     ar_dest,
    output logic [ID_WIDTH-1:0]               ar_front_id,
    output logic [ADDR_WIDTH-1:0]             ar_front_addr,
    output logic [LEN_WIDTH-1:0]              ar_front_len,
    output logic [SIZE_WIDTH-1:0]             ar_front_size,
    output logic [1:0]                        ar_front_burst,
    input  logic                              ar_pop,
    // AW FIFO head toward crossbar
    output logic                              aw_empty,
    output logic [SB-1:0]                     aw_dest,
    output logic [ID_WIDTH-1:0]               aw_front_id,
    output logic [ADDR_WIDTH-1:0]             aw_front_addr,
    output logic [LEN_WIDTH-1:0]              aw_front_len,
    output logic [SIZE_WIDTH-1:0]             aw_front_size,
    output logic [1:0]                        aw_front_burst,
    input  logic                              aw_pop,
    // W FIFO head toward crossbar
    output logic                              w_empty,
    output logic [DATA_WIDTH-1:0]             w_front_data,
    output logic [STRB_WIDTH-1:0]             w_front_strb,
    output logic                              w_front_last,
    input  logic                              w_pop,
    // R return queues from slaves
    input  logic [SLAVES-1:0]                 r_ret_empty,
    input  logic [SLAVES-1:0][ID_WIDTH-1:0]   r_ret_id,
    input  logic [SLAVES-1:0][DATA_WIDTH-1:0] r_ret_data,
    input  logic [SLAVES-1:0][1:0]            r_ret_resp,
    input  logic [SLAVES-1:0]                 r_ret_last,
    output logic [SLAVES-1:0]                 r_ret_pop,
    // B return queues from slaves
    input  logic [SLAVES-1:0]                 b_ret_empty,
    input  logic [SLAVES-1:0][ID_WIDTH-1:0]   b_ret_id,
    input  logic [SLAVES-1:0][1:0]            b_ret_resp,
    output logic [SLAVES-1:0]                 b_ret_pop
);
    typedef struct packed {
        logic [SB-1:0]         dest;
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic [SIZE_WIDTH-1:0] size;
        logic [1:0]            burst;
    } ax_hdr_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic                  last;
    } w_dat_t;

    typedef enum logic {R_IDLE, R_BUSY} r_state_t;
    typedef enum logic {B_IDLE, B_BUSY} b_state_t;

    // Round-robin search: first requester at or above start, wrapping at SLAVES.
    function automatic logic [SB-1:0] rr_pick(input logic [SLAVES-1:0] req, input logic [SB-1:0] start);
        logic [SB-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < SLAVES; i++) begin
            idx = (int'(start) + i) % SLAVES;
            if (!found && req[idx]) begin
                pick  = SB'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Index after g, wrapping to zero past the last slave.
    function automatic logic [SB-1:0] rr_next(input logic [SB-1:0] g);
        if (int'(g) == SLAVES - 1) return '0;
        return g + SB'(1);
    endfunction

    // ---------------- request FIFOs ----------------
    ax_hdr_t ar_in, ar_head, aw_in, aw_head;
    w_dat_t  w_in, w_head;
    logic    ar_full, aw_full, w_full;

    // Destination slave is the top address bits, captured alongside the entry.
    assign ar_in = {ARADDR[ADDR_WIDTH-1 -: SB], ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
    assign aw_in = {AWADDR[ADDR_WIDTH-1 -: SB], AWID, AWADDR, AWLEN, AWSIZE, AWBURST};
    assign w_in  = {WDATA, WSTRB, WLAST};

    // READY never looks at the pop side, so a full FIFO cannot pass through.
    assign ARREADY = ~ar_full & ARESETn;
    assign AWREADY = ~aw_full & ARESETn;
    assign WREADY  = ~w_full & ARESETn;

    xbar_fifo #(.WIDTH($bits(ax_hdr_t)), .DEPTH(DEPTH)) u_ar_fifo (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .push(ARVALID & ARREADY), .push_dat(ar_in),
        .pop(ar_pop), .pop_dat(ar_head),
        .empty(ar_empty), .full(ar_full)
    );

    xbar_fifo #(.WIDTH($bits(ax_hdr_t)), .DEPTH(DEPTH)) u_aw_fifo (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .push(AWVALID & AWREADY), .push_dat(aw_in),
        .pop(aw_pop), .pop_dat(aw_head),
        .empty(aw_empty), .full(aw_full)
    );

    xbar_fifo #(.WIDTH($bits(w_dat_t)), .DEPTH(DEPTH)) u_w_fifo (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .push(WVALID & WREADY), .push_dat(w_in),
        .pop(w_pop), .pop_dat(w_head),
        .empty(w_empty), .full(w_full)
    );

    assign ar_dest        = ar_head.dest;
    assign ar_front_id    = ar_head.id;
    assign ar_front_addr  = ar_head.addr;
    assign ar_front_len   = ar_head.len;
    assign ar_front_size  = ar_head.size;
    assign ar_front_burst = ar_head.burst;

    assign aw_dest        = aw_head.dest;
    assign aw_front_id    = aw_head.id;
    assign aw_front_addr  = aw_head.addr;
    assign aw_front_len   = aw_head.len;
    assign aw_front_size  = aw_head.size;
    assign aw_front_burst = aw_head.burst;

    assign w_front_data   = w_head.data;
    assign w_front_strb   = w_head.strb;
    assign w_front_last   = w_head.last;

    // ---------------- R return ----------------
    r_state_t      r_state;
    logic [SB-1:0] r_grant;
    logic [SB-1:0] r_rr;
    logic          r_hs;

    // Payload follows the granted slave; grant is frozen for the burst so it stays stable.
    assign RVALID = (r_state == R_BUSY) & ~r_ret_empty[r_grant] & ARESETn;
    assign RID    = r_ret_id[r_grant];
    assign RDATA  = r_ret_data[r_grant];
    assign RRESP  = r_ret_resp[r_grant];
    assign RLAST  = r_ret_last[r_grant];
    assign r_hs   = RVALID & RREADY;

    // Pop only the granted slave queue, and only on an accepted beat.
    always_comb begin
        r_ret_pop          = '0;
        r_ret_pop[r_grant] = r_hs;
    end

    // Grant a whole burst at a time; release after the last beat is accepted.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            r_grant <= '0;
            r_rr    <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (~r_ret_empty != '0) begin
                        r_grant <= rr_pick(~r_ret_empty, r_rr);
                        r_state <= R_BUSY;
                    end
                end
                R_BUSY: begin
                    if (r_hs && RLAST) begin
                        r_rr    <= rr_next(r_grant);
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- B return ----------------
    b_state_t      b_state;
    logic [SB-1:0] b_grant;
    logic [SB-1:0] b_rr;
    logic          b_hs;

    assign BVALID = (b_state == B_BUSY) & ~b_ret_empty[b_grant] & ARESETn;
    assign BID    = b_ret_id[b_grant];
    assign BRESP  = b_ret_resp[b_grant];
    assign b_hs   = BVALID & BREADY;

    // Pop only the granted slave queue on an accepted response.
    always_comb begin
        b_ret_pop          = '0;
        b_ret_pop[b_grant] = b_hs;
    end

    // Each write response is a single beat, so every handshake ends the grant.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            b_state <= B_IDLE;
            b_grant <= '0;
            b_rr    <= '0;
        end else begin
            case (b_state)
                B_IDLE: begin
                    if (~b_ret_empty != '0) begin
                        b_grant <= rr_pick(~b_ret_empty, b_rr);
                        b_state <= B_BUSY;
                    end
                end
                B_BUSY: begin
                    if (b_hs) begin
                        b_rr    <= rr_next(b_grant);
                        b_state <= B_IDLE;
                    end
                end
                default: b_state <= B_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xbar_slave_port.sv
// Directed bench for xbar_slave_port: request FIFOs, R/B round-robin return, reset behaviour.
// Inputs change 1 time unit after ACLK rises; outputs are checked 1 unit later, well before the next edge.
// Slave return queues are modelled here as small arrays that advance on the pops the DUT issues.
module tb_xbar_slave_port;
    logic        ACLK, ARESETn;
    logic [3:0]  ARID, AWID;
    logic [31:0] ARADDR, AWADDR;
    logic [3:0]  ARLEN, AWLEN;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST;
    logic        ARVALID, ARREADY, AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic [3:0]  RID, BID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP, BRESP;
    logic        RLAST, RVALID, RREADY, BVALID, BREADY;
    logic        ar_empty, aw_empty, w_empty;
    logic [0:0]  ar_dest, aw_dest;
    logic [3:0]  ar_front_id, aw_front_id, ar_front_len, aw_front_len;
    logic [31:0] ar_front_addr, aw_front_addr;
    logic [2:0]  ar_front_size, aw_front_size;
    logic [1:0]  ar_front_burst, aw_front_burst;
    logic        ar_pop, aw_pop, w_pop;
    logic [31:0] w_front_data;
    logic [3:0]  w_front_strb;
    logic        w_front_last;
    logic [1:0]       r_ret_empty, r_ret_last, r_ret_pop;
    logic [1:0][3:0]  r_ret_id;
    logic [1:0][31:0] r_ret_data;
    logic [1:0][1:0]  r_ret_resp;
    logic [1:0]       b_ret_empty, b_ret_pop;
    logic [1:0][3:0]  b_ret_id;
    logic [1:0][1:0]  b_ret_resp;

    int n_chk = 0;
    int n_pass = 0;

    // slave R queue model
    logic [31:0] rq_data [2][16];
    logic        rq_last [2][16];
    int          rq_n [2];
    int          rq_h [2];

    // expected tables
    logic [31:0] ar_tab [4] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_1000, 32'h8000_1000};
    logic [0:0]  ar_dst [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] aw_tab [4] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};
    logic        r1_v [8]   = '{0, 1, 1, 1, 1, 0, 1, 0};
    logic [31:0] r1_d [8]   = '{0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 32'hB0, 0};
    logic        r1_l [8]   = '{0, 0, 0, 0, 1, 0, 1, 0};
    logic [3:0]  r1_id [8]  = '{0, 3, 3, 3, 3, 0, 5, 0};
    logic [1:0]  r1_p [8]   = '{0, 1, 1, 1, 1, 0, 2, 0};
    logic        b_v [6]    = '{0, 1, 0, 1, 0, 1};
    logic [3:0]  b_id [6]   = '{0, 3, 0, 5, 0, 3};
    logic [1:0]  b_p [6]    = '{0, 1, 0, 2, 0, 1};

    xbar_slave_port dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ar_empty(ar_empty), .ar_dest(ar_dest), .ar_front_id(ar_front_id), .ar_front_addr(ar_front_addr),
        .ar_front_len(ar_front_len), .ar_front_size(ar_front_size), .ar_front_burst(ar_front_burst), .ar_pop(ar_pop),
        .aw_empty(aw_empty), .aw_dest(aw_dest), .aw_front_id(aw_front_id), .aw_front_addr(aw_front_addr),
        .aw_front_len(aw_front_len), .aw_front_size(aw_front_size), .aw_front_burst(aw_front_burst), .aw_pop(aw_pop),
        .w_empty(w_empty), .w_front_data(w_front_data), .w_front_strb(w_front_strb), .w_front_last(w_front_last),
        .w_pop(w_pop),
        .r_ret_empty(r_ret_empty), .r_ret_id(r_ret_id), .r_ret_data(r_ret_data), .r_ret_resp(r_ret_resp),
        .r_ret_last(r_ret_last), .r_ret_pop(r_ret_pop),
        .b_ret_empty(b_ret_empty), .b_ret_id(b_ret_id), .b_ret_resp(b_ret_resp), .b_ret_pop(b_ret_pop)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Present the head of each modelled slave queue.
    task automatic drive_ret();
        for (int s = 0; s < 2; s++) begin
            r_ret_empty[s] = (rq_h[s] == rq_n[s]);
            r_ret_data[s]  = rq_data[s][rq_h[s] % 16];
            r_ret_last[s]  = rq_last[s][rq_h[s] % 16];
            r_ret_id[s]    = (s == 0) ? 4'h3 : 4'h5;
            r_ret_resp[s]  = 2'b00;
        end
    endtask

    task automatic r_load(input int s, input logic [31:0] d, input logic l);
        rq_data[s][rq_n[s]] = d;
        rq_last[s][rq_n[s]] = l;
        rq_n[s]++;
        drive_ret();
    endtask

    // One clock: pops seen before the edge advance the slave model after it.
    task automatic cyc();
        logic [1:0] rp;
        rp = r_ret_pop;
        @(posedge ACLK);
        #1;
        for (int s = 0; s < 2; s++) if (rp[s]) rq_h[s]++;
        drive_ret();
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        ARVALID = 0; AWVALID = 0; WVALID = 0; RREADY = 0; BREADY = 0;
        ar_pop = 0; aw_pop = 0; w_pop = 0;
        b_ret_empty = 2'b11;
        for (int s = 0; s < 2; s++) begin rq_n[s] = 0; rq_h[s] = 0; end
        drive_ret();
        cyc();
        cyc();
        ARESETn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 3'd2; ARBURST = 2'b01;
        AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 3'd2; AWBURST = 2'b01;
        WDATA = 0; WSTRB = 0; WLAST = 0;
        b_ret_id = {4'h5, 4'h3};
        b_ret_resp = '0;

        // ---- reset state: held in reset with requests pending ----
        do_reset();
        ARESETn = 1'b0;
        ARVALID = 1; AWVALID = 1; WVALID = 1; RREADY = 1; BREADY = 1;
        b_ret_empty = 2'b00;
        r_load(0, 32'h55, 1'b1);
        #1;
        chk("rst_arready", ARREADY, 0);
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_r_pop", r_ret_pop, 0);
        chk("rst_b_pop", b_ret_pop, 0);
        cyc();
        chk("rst_ar_empty", ar_empty, 1);
        chk("rst_aw_empty", aw_empty, 1);
        chk("rst_w_empty", w_empty, 1);
        do_reset();
        #1;
        chk("post_rst_arready", ARREADY, 1);

        // ---- AR FIFO fill, full, drain with dest ----
        for (int i = 0; i < 4; i++) begin
            ARVALID = 1; ARADDR = ar_tab[i]; ARID = 4'(i); ARLEN = 4'(i + 1);
            #1;
            chk($sformatf("ar_ready_%0d", i), ARREADY, 1);
            cyc();
        end
        ARADDR = 32'hFFFF_FFFF;
        #1;
        chk("ar_full_ready", ARREADY, 0);
        ARVALID = 0;
        ar_pop = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("ar_dest_%0d", i), ar_dest, ar_dst[i]);
            chk($sformatf("ar_addr_%0d", i), ar_front_addr, ar_tab[i]);
            chk($sformatf("ar_id_%0d", i), ar_front_id, i);
            chk($sformatf("ar_len_%0d", i), ar_front_len, i + 1);
            cyc();
        end
        #1;
        chk("ar_drained", ar_empty, 1);
        cyc();
        ar_pop = 0;
        ARVALID = 1; ARADDR = 32'h8000_2000; ARID = 4'h9;
        cyc();
        ARVALID = 0;
        #1;
        chk("ar_pop_empty_ignored", ar_empty, 0);
        chk("ar_after_empty_pop_addr", ar_front_addr, 32'h8000_2000);
        chk("ar_after_empty_pop_dest", ar_dest, 1);
        ar_pop = 1;
        cyc();
        ar_pop = 0;
        #1;
        chk("ar_empty_again", ar_empty, 1);

        // ---- AW full with simultaneous push and pop ----
        for (int i = 0; i < 4; i++) begin
            AWVALID = 1; AWADDR = aw_tab[i]; AWID = 4'(i);
            cyc();
        end
        AWADDR = 32'h5000_0000; aw_pop = 1;
        #1;
        chk("aw_full_pop_ready", AWREADY, 0);
        chk("aw_head0", aw_front_addr, 32'h1000_0000);
        cyc();
        AWVALID = 0; aw_pop = 0;
        #1;
        chk("aw_occ3_ready", AWREADY, 1);
        aw_pop = 1;
        for (int i = 1; i < 4; i++) begin
            #1;
            chk($sformatf("aw_head_%0d", i), aw_front_addr, aw_tab[i]);
            cyc();
        end
        aw_pop = 0;
        #1;
        chk("aw_no_passthrough", aw_empty, 1);

        // ---- W FIFO ----
        WVALID = 1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WLAST = 0;
        #1;
        chk("w_ready", WREADY, 1);
        cyc();
        WDATA = 32'h1234_5678; WSTRB = 4'h3; WLAST = 1;
        cyc();
        WVALID = 0;
        #1;
        chk("w_data0", w_front_data, 32'hDEAD_BEEF);
        chk("w_strb0", w_front_strb, 4'hF);
        w_pop = 1;
        cyc();
        #1;
        chk("w_data1", w_front_data, 32'h1234_5678);
        chk("w_last1", w_front_last, 1);
        cyc();
        w_pop = 0;
        #1;
        chk("w_empty", w_empty, 1);

        // ---- R: burst from slave0 then single from slave1 ----
        do_reset();
        RREADY = 1;
        r_load(0, 32'hA0, 0); r_load(0, 32'hA1, 0); r_load(0, 32'hA2, 0); r_load(0, 32'hA3, 1);
        r_load(1, 32'hB0, 1);
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("r1_vld_c%0d", c), RVALID, r1_v[c]);
            chk($sformatf("r1_pop_c%0d", c), r_ret_pop, r1_p[c]);
            if (r1_v[c]) begin
                chk($sformatf("r1_data_c%0d", c), RDATA, r1_d[c]);
                chk($sformatf("r1_id_c%0d", c), RID, r1_id[c]);
                chk($sformatf("r1_last_c%0d", c), RLAST, r1_l[c]);
            end
            cyc();
        end

        // ---- R: RREADY low mid-burst ----
        do_reset();
        RREADY = 1;
        r_load(0, 32'hE0, 0); r_load(0, 32'hE1, 0); r_load(0, 32'hE2, 0); r_load(0, 32'hE3, 1);
        #1;
        chk("stall_idle", RVALID, 0);
        cyc();
        #1;
        chk("stall_beat0", RDATA, 32'hE0);
        cyc();
        RREADY = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall_vld_%0d", k), RVALID, 1);
            chk($sformatf("stall_data_%0d", k), RDATA, 32'hE1);
            chk($sformatf("stall_pop_%0d", k), r_ret_pop, 0);
            cyc();
        end
        RREADY = 1;
        #1;
        chk("stall_resume_pop", r_ret_pop, 2'b01);
        chk("stall_resume_data", RDATA, 32'hE1);
        cyc();
        #1;
        chk("stall_beat2", RDATA, 32'hE2);
        cyc();
        #1;
        chk("stall_beat3", RDATA, 32'hE3);
        chk("stall_last", RLAST, 1);
        cyc();
        #1;
        chk("stall_done", RVALID, 0);

        // ---- B: alternating grant ----
        do_reset();
        b_ret_empty = 2'b00;
        BREADY = 1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("b_vld_c%0d", c), BVALID, b_v[c]);
            chk($sformatf("b_pop_c%0d", c), b_ret_pop, b_p[c]);
            if (b_v[c]) chk($sformatf("b_id_c%0d", c), BID, b_id[c]);
            cyc();
        end

        // ---- reset during an R burst ----
        do_reset();
        RREADY = 1;
        r_load(0, 32'hC0, 1);
        r_load(1, 32'hD0, 0); r_load(1, 32'hD1, 0); r_load(1, 32'hD2, 0); r_load(1, 32'hD3, 1);
        ARVALID = 1; ARADDR = 32'h8000_0000;
        #1;
        chk("mr_c0_idle", RVALID, 0);
        cyc();
        ARVALID = 0;
        #1;
        chk("mr_c1_data", RDATA, 32'hC0);
        chk("mr_ar_loaded", ar_empty, 0);
        cyc();
        #1;
        chk("mr_c2_bubble", RVALID, 0);
        cyc();
        #1;
        chk("mr_c3_data", RDATA, 32'hD0);
        cyc();
        ARESETn = 0; ARVALID = 1;
        #1;
        chk("mr_rst_rvalid", RVALID, 0);
        chk("mr_rst_pop", r_ret_pop, 0);
        chk("mr_rst_arready", ARREADY, 0);
        cyc();
        ARESETn = 1; ARVALID = 0;
        r_load(0, 32'hC1, 1);
        #1;
        chk("mr_post_rvalid", RVALID, 0);
        chk("mr_ar_empty", ar_empty, 1);
        chk("mr_aw_empty", aw_empty, 1);
        chk("mr_w_empty", w_empty, 1);
        cyc();
        #1;
        chk("mr_rr0_id", RID, 4'h3);
        chk("mr_rr0_data", RDATA, 32'hC1);
        cyc();
        #1;
        chk("mr_bubble2", RVALID, 0);
        cyc();
        #1;
        chk("mr_resume_data", RDATA, 32'hD1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/xbar_slave_port.md
XBAR_SLAVE_PORT -- requirements
Module: xbar_slave_port

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, meaning outer-master AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning address width.
REQ-003 SHALL have parameter LEN_WIDTH / SIZE_WIDTH, defaults 4 / 3, meaning burst length / size widths.
REQ-004 SHALL have parameter DATA_WIDTH / STRB_WIDTH, defaults 32 / 4, meaning data / strobe widths.
REQ-005 SHALL have parameter DEPTH, default 4 (power of 2, >=2), meaning entries per request FIFO.
REQ-006 SHALL have parameter SLAVES, default 2 (>=2), meaning downstream slave count; SB = $clog2(SLAVES).
REQ-007 SHALL have ports ACLK in 1 (clock) and ARESETn in 1 (reset, synchronous, active-low).
REQ-008 SHALL have ports ARID/ARADDR/ARLEN/ARSIZE/ARBURST, ARVALID in, ARREADY out: outer AR channel.
REQ-009 SHALL have ports AWID/AWADDR/AWLEN/AWSIZE/AWBURST, AWVALID in, AWREADY out: outer AW channel.
REQ-010 SHALL have ports WDATA/WSTRB/WLAST, WVALID in, WREADY out: outer W channel.
REQ-011 SHALL have ports RID/RDATA/RRESP/RLAST, RVALID out, RREADY in: outer R channel.
REQ-012 SHALL have ports BID/BRESP, BVALID out, BREADY in: outer B channel.
REQ-013 SHALL have ports ar_empty out 1, ar_dest out SB, ar_front_* out (AR payload), ar_pop in 1: AR FIFO head toward crossbar.
REQ-014 SHALL have ports aw_empty out 1, aw_dest out SB, aw_front_* out (AW payload), aw_pop in 1: AW FIFO head.
REQ-015 SHALL have ports w_empty out 1, w_front_* out (W payload), w_pop in 1: W FIFO head.
REQ-016 SHALL have ports r_ret_empty in [SLAVES], r_ret_* in [SLAVES] (R payload per slave), r_ret_pop out [SLAVES] one-hot.
REQ-017 SHALL have ports b_ret_empty in [SLAVES], b_ret_* in [SLAVES] (B payload per slave), b_ret_pop out [SLAVES] one-hot.

Function
REQ-018 AR, AW, W SHALL each be a DEPTH-entry FIFO, pointers of $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH.
REQ-019 ARREADY SHALL equal ~ar_full & ARESETn; push on ARVALID & ARREADY; AW/W identical with own full.
REQ-020 A full FIFO SHALL deassert READY even when a pop occurs in the same cycle (no pass-through).
REQ-021 Pop SHALL occur on *_pop & ~*_empty; pop on empty SHALL be ignored, pointers unchanged.
REQ-022 Simultaneous push and pop on non-empty, non-full FIFO SHALL leave occupancy unchanged.
REQ-023 ar_dest / aw_dest SHALL be head-entry ADDR[ADDR_WIDTH-1 -: SB], registered at push with the entry.
REQ-024 R return SHALL use a 2-state FSM R_IDLE / R_BUSY with registered r_grant (SB bits) and r_rr pointer.
REQ-025 R_IDLE: if any ~r_ret_empty, latch r_grant = first non-empty index searching r_rr upward with wrap, go R_BUSY.
REQ-026 R_BUSY: RVALID = ~r_ret_empty[r_grant]; R payload = r_ret_*[r_grant]; r_ret_pop[r_grant] = RVALID & RREADY.
REQ-027 R_BUSY SHALL hold r_grant through the whole burst; on handshake with RLAST=1 go R_IDLE, r_rr <= r_grant+1 mod SLAVES.
REQ-028 RVALID SHALL be 0 in R_IDLE (one-cycle arbitration bubble between bursts).
REQ-029 B return SHALL use identical FSM B_IDLE / B_BUSY; every handshake (BVALID & BREADY) ends grant, b_rr <= b_grant+1.
REQ-030 Once VALID asserted on R or B, payload SHALL stay stable until handshake.

Reset
REQ-031 On ARESETn=0 at ACLK edge: all FIFO pointers 0, *_empty=1, FSMs IDLE, r_grant=b_grant=r_rr=b_rr=0.
REQ-032 While ARESETn=0: ARREADY=AWREADY=WREADY=0, RVALID=BVALID=0, r_ret_pop=b_ret_pop=0.
REQ-033 Reset mid-burst SHALL abandon the burst and discard FIFO contents; no pop issued that cycle.

Verification
REQ-034 Push 4 AR (ADDR 0x0000_0000, 0x8000_0000, ...), ar_pop=0 -> ARREADY=0 after 4th; ar_dest 0 then 1 as popped.
REQ-035 Full AW FIFO, AWVALID=1 and aw_pop=1 same cycle -> AWREADY=0, occupancy 4->3 next cycle.
REQ-036 r_ret_empty={0,0}, slave0 burst LEN=3, slave1 single -> 4 beats slave0 (no interleave), bubble, then slave1.
REQ-037 RREADY=0 for 3 cycles mid-burst -> RVALID held, RDATA stable, r_ret_pop=0.
REQ-038 Both b_ret non-empty continuously, BREADY=1 -> BID alternates slave0, slave1, slave0, one B per 2 cycles.
REQ-039 ARESETn low 1 cycle during R burst beat 2 -> RVALID=0, all empties=1, r_rr=0 next cycle.
